step_pattern_kbd: RTL
=====================

// Module: step_pattern_kbd
// PURPOSE
//  Upstream input stage of the step sequencer. Debounces 8 board push-buttons.
//  Toggles one step-enable bit per clean press.
//  Presents the 8-bit step pattern to the sequencer loop controller's kbd_in.
//  picoVersat can also read/overwrite the pattern and poll press events over a small register port.
// PARAMETERS
//  N_STEPS     8        number of buttons / pattern bits
//  SAMPLE_DIV  500000   clk cycles per debounce sample tick (10 ms @ 50 MHz)
//  DB_SAMPLES  4        consecutive disagreeing samples needed to flip a debounced state
//  ACTIVE_LOW  0        1: buttons read 0 when pressed (inverted after synchroniser)
// PORTS
//  clk          in   1        system clock
//  rst          in   1        reset, asynchronous, active-high
//  btn_in       in   N_STEPS  raw asynchronous buttons, bit i = step i
//  lock         in   1        1: presses still debounce and flag events, but do not toggle the pattern
//  sel          in   1        register access strobe, one clk wide
//  we           in   1        1 = write, 0 = read (qualified by sel)
//  addr         in   2        register select
//  data_in      in   8        write data
//  data_out     out  8        read data, registered, valid the cycle after sel
//  pattern_out  out  N_STEPS  step pattern to the sequencer (kbd_in)
// BEHAVIOUR
//  Reset: pattern_out=0, data_out=0, events=0, debounced state=0, sync flops=0, prescaler=0.
//  Synchroniser: 2 flops per button, then optional inversion.
//  Prescaler: counts 0..SAMPLE_DIV-1; tick=1 for one clk when the count wraps to 0.
//  Debounce, per button, on tick only:
//   - sample != state: cnt++; at cnt==DB_SAMPLES-1, state flips and cnt=0.
//   - sample == state: cnt=0.
//   - cnt width = clog2(DB_SAMPLES). Never wraps.
//  Press = state 0->1, one-clk pulse. Releases (1->0) generate nothing.
//  Worst-case press latency: 2 + SAMPLE_DIV*DB_SAMPLES clk.
//  Press effects: toggles pattern bit i when lock=0. Always sets sticky event bit i.
//  Registers:
//   addr 0  R/W  pattern (write replaces all bits)
//   addr 1  W    pattern &= ~data_in (clear mask)
//   addr 1  R    pattern
//   addr 2  R    debounced state
//   addr 2  W    ignored
//   addr 3  R    event flags, cleared by the read
//   addr 3  W    ignored
//  Simultaneous events:
//   - CPU write to addr 0/1 and a press in the same clk: CPU result wins on every bit.
//     The press event is still latched.
//   - Read of addr 3 and a press in the same clk: old flags are returned, the new press bit stays set.
//  Reset mid-debounce: all counters and states clear; a held button re-qualifies after reset.
//  pattern_out updates 1 clk after the press pulse or CPU write; it is never combinational from inputs.
//  N_STEPS<8: unused data bits read 0 and are ignored on write.
// STRUCTURE
//  Shared include (seq_defs.vh): SEQ_N_STEPS and the register address constants
//  PAT_ADDR=0, CLR_ADDR=1, DBS_ADDR=2, EVT_ADDR=3. The CPU-side decoder uses the same file.
//  Sub-module kbd_debounce: synchroniser, inversion, counter and state for one button.
//   - Inputs: clk, rst, tick, btn.
//   - Outputs: state, press.
//   - Instantiated N_STEPS times with generate.
//  Top holds the prescaler, pattern, event register and read mux.
// TESTING (SAMPLE_DIV=4, DB_SAMPLES=3)
//  1. Hold btn_in[2]=1 for 40 clk -> pattern_out=0x04 within 14 clk. Release, press again -> pattern_out=0x00.
//  2. Bounce btn_in[5]: 1 for 6 clk, 0 for 6 clk, repeated 4 times -> pattern_out and state stay 0x00.
//  3. Write addr0=0xA5, then read addr0 -> data_out=0xA5. Write addr1=0x05 -> pattern_out=0xA0.
//  4. Write addr0=0x00 in the same clk as a btn0 press pulse -> pattern_out=0x00.
//     Read addr3 -> 0x01. Read addr3 again -> 0x00.
//  5. lock=1, press btn7 -> pattern_out unchanged; addr3 reads 0x80.
//  6. Assert rst with btn3 held and 2 samples into debounce -> all outputs 0.
//     Deassert with btn3 still held -> bit3 sets after 3 further ticks.

Source files
------------

// File: rtl/step_pattern_kbd_pkg.sv
// step_pattern_kbd_pkg
//   Definitions shared by the step-pattern keyboard stage and the CPU-side
//   register decoder: the default step count, the register map, and a
//   counter-width helper.
package step_pattern_kbd_pkg;

    localparam int unsigned SEQ_N_STEPS = 8;

    // Register map seen by picoVersat.
    typedef enum logic [1:0] {
        PAT_ADDR = 2'd0,  // R/W pattern, write replaces all bits
        CLR_ADDR = 2'd1,  // W clear mask, R pattern
        DBS_ADDR = 2'd2,  // R debounced button state
        EVT_ADDR = 2'd3   // R press flags, cleared by the read
    } reg_addr_e;

    // Width of a counter that has to hold 0..n-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_pattern_kbd_debounce.sv
// kbd_debounce
//   One push-button: 2-flop synchroniser, optional inversion, and a
//   consecutive-sample debouncer advanced only on the shared sample tick.
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   tick   in   one-clk sample strobe from the prescaler
//   btn    in   raw asynchronous button
//   state  out  debounced button state (1 = pressed)
//   press  out  one-clk pulse on a debounced 0->1 transition
module kbd_debounce
    import step_pattern_kbd_pkg::*;
#(
    parameter int unsigned DB_SAMPLES = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic state,
    output logic press
);

    localparam int unsigned CW = cnt_width(DB_SAMPLES);

    logic          sync1_q, sync2_q;
    logic          sample;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign sample = sync2_q ^ ACTIVE_LOW;

    // The counter holds how many consecutive disagreeing samples have been
    // seen before the current one; the DB_SAMPLES-th disagreement flips the
    // state, so the counter never exceeds DB_SAMPLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        if (tick) begin
            if (sample != state_q) begin
                if (cnt_q == CW'(DB_SAMPLES - 1)) begin
                    state_d = ~state_q;
                    cnt_d   = '0;
                    press   = ~state_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/step_pattern_kbd.sv
// step_pattern_kbd
//   Input stage of the step sequencer. Debounces N_STEPS push-buttons, toggles
//   one pattern bit per clean press (unless locked), latches sticky press
//   events, and exposes pattern / state / events on a small register port.
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   btn_in       in   raw buttons, bit i = step i
//   lock         in   1: presses flag events but do not toggle the pattern
//   sel          in   register access strobe, one clk wide
//   we           in   1 = write, 0 = read (qualified by sel)
//   addr         in   register select
//   data_in      in   write data
//   data_out     out  registered read data, valid the cycle after sel
//   pattern_out  out  step pattern to the sequencer (kbd_in)
module step_pattern_kbd
    import step_pattern_kbd_pkg::*;
#(
    parameter int unsigned N_STEPS    = SEQ_N_STEPS,
    parameter int unsigned SAMPLE_DIV = 500000,
    parameter int unsigned DB_SAMPLES = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_STEPS-1:0] btn_in,
    input  logic               lock,
    input  logic               sel,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    output logic [N_STEPS-1:0] pattern_out
);

    localparam int unsigned PW = cnt_width(SAMPLE_DIV);

    logic [PW-1:0]      presc_q, presc_d;
    logic               tick_q, tick_d;
    logic [N_STEPS-1:0] db_state;
    logic [N_STEPS-1:0] press_vec;
    logic [N_STEPS-1:0] pattern_q, pattern_d;
    logic [N_STEPS-1:0] events_q, events_d;
    logic [7:0]         data_out_q, data_out_d;
    logic [N_STEPS-1:0] din;
    logic [N_STEPS-1:0] rd_val;
    reg_addr_e          reg_sel;

    for (genvar i = 0; i < N_STEPS; i++) begin : g_btn
        kbd_debounce #(
            .DB_SAMPLES (DB_SAMPLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick_q),
            .btn   (btn_in[i]),
            .state (db_state[i]),
            .press (press_vec[i])
        );
    end

    // Tick is high for the one clk in which the prescaler sits at 0 after a wrap.
    always_comb begin
        tick_d  = (presc_q == PW'(SAMPLE_DIV - 1));
        presc_d = tick_d ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        din     = data_in[N_STEPS-1:0];
        reg_sel = reg_addr_e'(addr);

        case (reg_sel)
            DBS_ADDR: rd_val = db_state;
            EVT_ADDR: rd_val = events_q;
            default:  rd_val = pattern_q;
        endcase

        data_out_d = data_out_q;
        if (sel && !we) begin
            data_out_d = 8'(rd_val);
        end

        // Clearing on read happens before new presses are merged in, so a
        // press landing on the read cycle stays flagged for the next read.
        events_d = events_q;
        if (sel && !we && reg_sel == EVT_ADDR) begin
            events_d = '0;
        end
        events_d = events_d | press_vec;

        // A CPU write overrides any press toggle on every bit in that clk.
        pattern_d = pattern_q ^ (lock ? '0 : press_vec);
        if (sel && we) begin
            case (reg_sel)
                PAT_ADDR: pattern_d = din;
                CLR_ADDR: pattern_d = pattern_q & ~din;
                default:  pattern_d = pattern_q ^ (lock ? '0 : press_vec);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            pattern_q  <= '0;
            events_q   <= '0;
            data_out_q <= '0;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            pattern_q  <= pattern_d;
            events_q   <= events_d;
            data_out_q <= data_out_d;
        end
    end

    assign pattern_out = pattern_q;
    assign data_out    = data_out_q;

endmodule
